piso_shift_serializer: RTL and testbench
========================================

// Module: piso_shift_serializer
// PURPOSE
//  Parallel-in serial-out shifter; transmit-side counterpart of the 4-bit SIPO.
//  Accepts a WIDTH-bit word via valid/ready, then drives it one bit per clk on so.
//  Marks each frame with frame_start so a SIPO receiver can align word boundaries.
//  Supports back-to-back words with no idle gap.
// PARAMETERS
//  WIDTH      4  bits per word, >= 2
//  MSB_FIRST  1  1: pdata[WIDTH-1] goes out first; 0: pdata[0] goes out first
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-low
//  pdata        in   WIDTH  parallel word, sampled on accept
//  load_valid   in   1      pdata valid
//  load_ready   out  1      block can accept a word this cycle
//  so           out  1      serial data out, registered
//  so_valid     out  1      so carries a frame bit this cycle
//  frame_start  out  1      high with the first bit of each frame
//  busy         out  1      high while a frame is in flight
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, so=0, so_valid=0, frame_start=0,
//    busy=0, bit counter=0, shift reg=0. load_ready=0 while rst==0.
//    A reset mid-frame aborts the frame. The remaining bits are never sent.
//  - Accept = load_valid & load_ready at an edge T. pdata is captured at T.
//    pdata is ignored at every other edge.
//  - Latency: the first bit appears on so in cycle T+1.
//    Bit k (0..WIDTH-1) appears in cycle T+1+k with so_valid=1.
//    frame_start=1 only in cycle T+1.
//  - Bit order: MSB_FIRST=1 sends pdata[WIDTH-1] first, down to pdata[0].
//    MSB_FIRST=0 sends pdata[0] first, up to pdata[WIDTH-1].
//  - States:
//    IDLE -> SHIFT on accept.
//    SHIFT holds for WIDTH cycles, counter 0..WIDTH-1.
//    On the last bit: SHIFT -> PARITY if PARITY_EN is defined.
//    Otherwise: SHIFT -> SHIFT on accept, or SHIFT -> IDLE.
//    PARITY -> SHIFT on accept, else PARITY -> IDLE.
//  - load_ready (combinational, rst==1) is high in three cases:
//    state IDLE; the last frame cycle (last data bit, or the parity bit when
//    PARITY_EN is defined); or state PARITY.
//    Otherwise load_ready is low, so load_valid held during a frame waits.
//  - Back-to-back: an accept in the last frame cycle starts the next frame's
//    bit 0 in the next cycle. so_valid stays high with no gap, and
//    frame_start pulses again.
//  - In IDLE: so_valid=0, busy=0, and so holds 0.
//    busy=1 in every cycle where so_valid=1.
//  - The counter wraps to 0 at each frame start and never exceeds WIDTH-1.
// CONFIGURATION
//  PARITY_EN defined:
//    Frame = WIDTH data bits + 1 even-parity bit (XOR of the captured word).
//    The parity bit is sent in cycle T+1+WIDTH with so_valid=1.
//    Frame length is WIDTH+1 cycles.
//  PARITY_EN undefined:
//    No PARITY state. Frame length is WIDTH cycles.
// TESTING (WIDTH=4 unless noted)
//  1. Reset: rst=0 for 2 edges, load_valid=1 -> so=0, so_valid=0, busy=0, load_ready=0.
//     After rst=1, load_ready=1.
//  2. MSB_FIRST=1, accept 4'b1011 at T -> so=1,0,1,1 in T+1..T+4.
//     frame_start=1 only in T+1. so_valid=0 in T+5.
//  3. MSB_FIRST=0, accept 4'b1011 -> so=1,1,0,1.
//  4. Back-to-back: 4'b1011, then 4'b0110 accepted in the last cycle of the first
//     frame -> 8 contiguous so_valid cycles, so=1,0,1,1,0,1,1,0.
//     frame_start pulses in cycles 1 and 5.
//  5. Hold load_valid=1 with 4'b1111 from T-1 through the frame -> exactly one
//     accept at T. The next accept occurs only in the last frame cycle.
//     so_valid=1 continuously with no gap.
//  6. rst=0 at T+2 of 4'b1011 -> so=0, so_valid=0 from T+3.
//     The next accept after rst=1 starts a clean frame.
//     PARITY_EN: 4'b1011 -> 1,0,1,1, then parity bit 1 in T+5.

Source files
------------

// File: rtl/piso_shift_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word via valid/ready and shifts it out
// one bit per clock with a frame_start marker. Optional even-parity bit per frame via `PARITY_EN.
module piso_shift_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             so_n, fs_n;
  logic             last_bit, accept;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] shreg_load, shreg_shift;
`ifdef PARITY_EN
  logic             par, par_n;
`endif

  // Handshake: a word transfers at a rising edge where load_valid and load_ready are
  // both high; load_ready is combinational from state and never depends on load_valid.
  assign last_bit   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PARITY_EN
  assign load_ready = rst && ((state == IDLE) || (state == PARITY));
`else
  assign load_ready = rst && ((state == IDLE) || last_bit);
`endif
  assign accept     = load_valid && load_ready;

  // shreg always holds the not-yet-sent bits aligned so the next one sits at the exit end.
  assign first_bit   = MSB_FIRST ? pdata[WIDTH-1] : pdata[0];
  assign shreg_load  = MSB_FIRST ? (pdata << 1) : (pdata >> 1);
  assign next_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shift = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  assign so_valid  = (state != IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    so_n    = so;
    fs_n    = 1'b0;
`ifdef PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        so_n = 1'b0;
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_n   = cnt + CW'(1);
          so_n    = next_bit;
          shreg_n = shreg_shift;
        end else begin
`ifdef PARITY_EN
          state_n = PARITY;
          so_n    = par;
`else
          state_n = IDLE;
          so_n    = 1'b0;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_n = IDLE;
        so_n    = 1'b0;
      end
`endif
      default: begin
        state_n = IDLE;
        so_n    = 1'b0;
      end
    endcase
    // A new frame overrides whatever the current state would do next.
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      so_n    = first_bit;
      shreg_n = shreg_load;
      fs_n    = 1'b1;
`ifdef PARITY_EN
      par_n   = ^pdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      so          <= 1'b0;
      frame_start <= 1'b0;
`ifdef PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      so          <= so_n;
      frame_start <= fs_n;
`ifdef PARITY_EN
      par         <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Bench for piso_shift_serializer: one MSB-first and one LSB-first instance share stimulus;
// expected {frame_start, so} pairs are queued on accept and popped by a negedge monitor.
module tb_piso_shift_serializer;

`ifdef PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] pdata;
  logic       load_valid;

  logic       ready_m, so_m, sov_m, fs_m, busy_m;
  logic       ready_l, so_l, sov_l, fs_l, busy_l;
  logic [1:0] dbg_m, dbg_l;

  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];

  int checks = 0;
  int errors = 0;
  int run_m = 0;
  int last_run = 0;

  piso_shift_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .pdata(pdata), .load_valid(load_valid), .load_ready(ready_m),
    .so(so_m), .so_valid(sov_m), .frame_start(fs_m), .busy(busy_m), .dbg_state(dbg_m)
  );

  piso_shift_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .pdata(pdata), .load_valid(load_valid), .load_ready(ready_l),
    .so(so_l), .so_valid(sov_l), .frame_start(fs_l), .busy(busy_l), .dbg_state(dbg_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bit k of a frame for each bit order, parity bit last.
  task automatic push_frame(input logic [3:0] w, input int n);
    for (int k = 0; k < FL && k < n; k++) begin
      logic bm, bl;
      if (k < 4) begin
        bm = w[3 - k];
        bl = w[k];
      end else begin
        bm = ^w;
        bl = ^w;
      end
      exp_m.push_back({(k == 0), bm});
      exp_l.push_back({(k == 0), bl});
    end
  endtask

  // driver: present word, wait for ready (bounded), queue expectations, complete the transfer
  task automatic send(input logic [3:0] w, input int npush);
    int bound;
    load_valid = 1'b1;
    pdata      = w;
    bound      = 0;
    while (!ready_m && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk("send_timeout", (bound >= 50), 0);
    push_frame(w, npush);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [1:0] e;
    if (sov_m) begin
      if (exp_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected: got bit %0b expected none at %0t", so_m, $time);
      end else begin
        e = exp_m.pop_front();
        chk("m_bit", {fs_m, so_m}, e);
      end
      run_m++;
    end else begin
      chk("m_idle", {fs_m, so_m}, 0);
      if (run_m != 0) last_run = run_m;
      run_m = 0;
    end
    chk("m_busy", busy_m, sov_m);
    if (sov_l) begin
      if (exp_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL l_unexpected: got bit %0b expected none at %0t", so_l, $time);
      end else begin
        e = exp_l.pop_front();
        chk("l_bit", {fs_l, so_l}, e);
      end
    end else begin
      chk("l_idle", {fs_l, so_l}, 0);
    end
    chk("l_busy", busy_l, sov_l);
  end

  initial begin
    int acc;
    rst        = 1'b0;
    load_valid = 1'b1;
    pdata      = 4'b1111;

    // 1: reset with load_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_so", {so_m, so_l}, 0);
    chk("rst_sov", {sov_m, sov_l}, 0);
    chk("rst_busy", {busy_m, busy_l}, 0);
    chk("rst_ready", {ready_m, ready_l}, 0);
    rst        = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("post_rst_ready", {ready_m, ready_l}, 2'b11);

    // 2/3: single frame 1011, both bit orders
    send(4'b1011, FL);
    idle(FL + 2);
    chk("single_len", last_run, FL);

    // 4: back-to-back frames
    send(4'b1011, FL);
    send(4'b0110, FL);
    idle(FL + 2);
    chk("b2b_len", last_run, 2 * FL);

    // 5: load_valid held high for three frame lengths
    load_valid = 1'b1;
    pdata      = 4'b1111;
    acc        = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      if (ready_m) begin
        acc++;
        push_frame(4'b1111, FL);
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    idle(FL + 2);
    chk("hold_accepts", acc, 3);
    chk("hold_len", last_run, 3 * FL);

    // 6: reset mid-frame, then a clean frame
    send(4'b1011, 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sov", {sov_m, sov_l}, 0);
    chk("abort_so", {so_m, so_l}, 0);
    chk("abort_ready", ready_m, 0);
    rst = 1'b1;
    idle(1);
    chk("abort_len", last_run, 2);
    send(4'b0101, FL);
    idle(FL + 2);
    chk("clean_len", last_run, FL);

    chk("queue_m_empty", exp_m.size(), 0);
    chk("queue_l_empty", exp_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
